// File: rtl/axi_rd_beat_resp.sv
// Per-beat AXI read responder: SRAM read issue, fixed-latency tag pipe,
// credit-protected response FIFO and R channel with full backpressure.
`ifndef ID_BITS
`define ID_BITS 4
`endif

module axi_rd_beat_resp #(
  parameter int masters    = 4,
  parameter int width      = 22,
  parameter int p_size     = 4,
  parameter int rd_latency = 2,
  parameter int depth      = 4,
  parameter int mem_bytes  = 4194304
) (
  input  logic                    CLK,
  input  logic                    RESETN,
  input  logic [masters-1:0]      I_MASTER,
  input  logic [`ID_BITS-1:0]     I_ID,
  input  logic [width-1:0]        I_ADDR,
  input  logic                    I_LAST,
  input  logic                    I_VALID,
  output logic                    I_READY,
  output logic                    MEM_CS,
  output logic [width-p_size-1:0] MEM_ADDR,
  input  logic [(8<<p_size)-1:0]  MEM_RDATA,
  output logic [masters-1:0]      R_MASTER,
  output logic [`ID_BITS-1:0]     R_ID,
  output logic [(8<<p_size)-1:0]  R_DATA,
  output logic [1:0]              R_RESP,
  output logic                    R_LAST,
  output logic                    R_VALID,
  input  logic                    R_READY
);

  localparam int DB = 8 << p_size;
  localparam int IB = `ID_BITS;
  localparam int PW = $clog2(depth);
  localparam int CW = PW + 1;
  localparam logic [63:0] LIM = 64'(mem_bytes);

  logic          in_range;
  logic          acc;
  logic          wr;
  logic          pop;
  logic [CW:0]   used;
  logic [CW-1:0] inf_q, inf_d;
  logic [CW-1:0] occ_q, occ_d;
  logic [PW-1:0] wp_q, rp_q;
  logic [DB-1:0] wdata;

  logic [rd_latency-1:0] tv_q;
  logic [rd_latency-1:0] tl_q;
  logic [masters-1:0]    tm_q [rd_latency];
  logic [IB-1:0]         ti_q [rd_latency];
  logic [1:0]            tr_q [rd_latency];

  logic [masters-1:0] fm_q [depth];
  logic [IB-1:0]      fi_q [depth];
  logic               fl_q [depth];
  logic [1:0]         fr_q [depth];
  logic [DB-1:0]      fd_q [depth];

  assign in_range = 64'(I_ADDR) < LIM;
  assign used     = {1'b0, inf_q} + {1'b0, occ_q};
  assign I_READY  = used < (CW+1)'(depth);
  assign acc      = I_VALID && I_READY;
  assign MEM_CS   = acc && in_range;
  assign MEM_ADDR = I_ADDR[width-1:p_size];

  assign wr    = tv_q[rd_latency-1];
  assign pop   = R_VALID && R_READY;
  assign wdata = (tr_q[rd_latency-1] == 2'b00) ? MEM_RDATA : '0;

  assign inf_d = inf_q + CW'(acc) - CW'(wr);
  assign occ_d = occ_q + CW'(wr) - CW'(pop);

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      tv_q  <= '0;
      wp_q  <= '0;
      rp_q  <= '0;
      inf_q <= '0;
      occ_q <= '0;
    end else begin
      tv_q[0] <= acc;
      for (int i = 1; i < rd_latency; i++)
        tv_q[i] <= tv_q[i-1];
      if (wr)
        wp_q <= wp_q + PW'(1);
      if (pop)
        rp_q <= rp_q + PW'(1);
      inf_q <= inf_d;
      occ_q <= occ_d;
      if (wr)
        assert (occ_q != CW'(depth));
    end
  end

  // Tag payload only matters where its valid bit is set.
  always_ff @(posedge CLK) begin
    tm_q[0] <= I_MASTER;
    ti_q[0] <= I_ID;
    tl_q[0] <= I_LAST;
    tr_q[0] <= in_range ? 2'b00 : 2'b11;
    for (int i = 1; i < rd_latency; i++) begin
      tm_q[i] <= tm_q[i-1];
      ti_q[i] <= ti_q[i-1];
      tl_q[i] <= tl_q[i-1];
      tr_q[i] <= tr_q[i-1];
    end
  end

  always_ff @(posedge CLK) begin
    if (wr) begin
      fm_q[wp_q] <= tm_q[rd_latency-1];
      fi_q[wp_q] <= ti_q[rd_latency-1];
      fl_q[wp_q] <= tl_q[rd_latency-1];
      fr_q[wp_q] <= tr_q[rd_latency-1];
      fd_q[wp_q] <= wdata;
    end
  end

  assign R_VALID  = occ_q != '0;
  assign R_MASTER = R_VALID ? fm_q[rp_q] : '0;
  assign R_ID     = R_VALID ? fi_q[rp_q] : '0;
  assign R_LAST   = R_VALID ? fl_q[rp_q] : 1'b0;
  assign R_RESP   = R_VALID ? fr_q[rp_q] : 2'b00;
  assign R_DATA   = R_VALID ? fd_q[rp_q] : '0;

endmodule

// File: tb/tb_axi_rd_beat_resp.sv
// Scoreboard bench for axi_rd_beat_resp with a fixed-latency SRAM model.
`ifndef ID_BITS
`define ID_BITS 4
`endif

module tb_axi_rd_beat_resp;

  localparam int M  = 4;
  localparam int W  = 22;
  localparam int P  = 4;
  localparam int L  = 2;
  localparam int D  = 4;
  localparam int MB = 4096;
  localparam int DB = 8 << P;
  localparam int IB = `ID_BITS;
  localparam int EW = M + IB + 1 + 2 + DB;

  logic          CLK = 1'b0;
  logic          RESETN = 1'b0;
  logic [M-1:0]  I_MASTER = '0;
  logic [IB-1:0] I_ID = '0;
  logic [W-1:0]  I_ADDR = '0;
  logic          I_LAST = 1'b0;
  logic          I_VALID = 1'b0;
  logic          I_READY;
  logic          MEM_CS;
  logic [W-P-1:0] MEM_ADDR;
  logic [DB-1:0] MEM_RDATA;
  logic [M-1:0]  R_MASTER;
  logic [IB-1:0] R_ID;
  logic [DB-1:0] R_DATA;
  logic [1:0]    R_RESP;
  logic          R_LAST;
  logic          R_VALID;
  logic          R_READY = 1'b1;

  int checks = 0;
  int errors = 0;
  int outs = 0;
  int cs_cnt = 0;
  bit rdone = 1'b0;
  logic [EW-1:0] sb [$];
  logic [DB-1:0] rdp [L];

  axi_rd_beat_resp #(
    .masters(M), .width(W), .p_size(P),
    .rd_latency(L), .depth(D), .mem_bytes(MB)
  ) dut (
    .CLK(CLK), .RESETN(RESETN),
    .I_MASTER(I_MASTER), .I_ID(I_ID), .I_ADDR(I_ADDR),
    .I_LAST(I_LAST), .I_VALID(I_VALID), .I_READY(I_READY),
    .MEM_CS(MEM_CS), .MEM_ADDR(MEM_ADDR), .MEM_RDATA(MEM_RDATA),
    .R_MASTER(R_MASTER), .R_ID(R_ID), .R_DATA(R_DATA),
    .R_RESP(R_RESP), .R_LAST(R_LAST), .R_VALID(R_VALID),
    .R_READY(R_READY)
  );

  always #5 CLK = ~CLK;

  function automatic logic [DB-1:0] f(input logic [W-P-1:0] a);
    logic [31:0] x;
    x = 32'(a);
    return {x * 32'h0100_0193, x + 32'h1234, ~x, x ^ 32'hCAFE_F00D};
  endfunction

  // SRAM model: unselected cycles return junk so DECERR zeroing is visible.
  always @(posedge CLK) begin
    rdp[0] <= MEM_CS ? f(MEM_ADDR) : {4{32'hDEAD_BEEF}};
    for (int i = 1; i < L; i++)
      rdp[i] <= rdp[i-1];
  end
  assign MEM_RDATA = rdp[L-1];

  task automatic chk(input string tag, input logic [255:0] got,
                     input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin : mon
    logic inr;
    logic [EW-1:0] ex;
    forever begin
      @(negedge CLK);
      if (!RESETN) begin
        sb.delete();
        outs = 0;
      end else begin
        inr = I_ADDR < W'(MB);
        chk("mem_cs", MEM_CS, I_VALID && I_READY && inr);
        if (MEM_CS) begin
          cs_cnt++;
          chk("mem_addr", MEM_ADDR, I_ADDR[W-1:P]);
        end
        if (R_VALID) begin
          if (sb.size() == 0)
            chk("stale_r", 1, 0);
          else
            chk("r_beat",
                {R_MASTER, R_ID, R_LAST, R_RESP, R_DATA}, sb[0]);
        end else begin
          chk("r_idle",
              {R_MASTER, R_ID, R_LAST, R_RESP, R_DATA}, 0);
        end
        if (R_VALID && R_READY && sb.size() > 0) begin
          void'(sb.pop_front());
          outs--;
        end
        if (I_VALID && I_READY) begin
          ex = {I_MASTER, I_ID, I_LAST,
                inr ? 2'b00 : 2'b11,
                inr ? f(I_ADDR[W-1:P]) : {DB{1'b0}}};
          sb.push_back(ex);
          outs++;
        end
        chk("credit", outs <= D, 1);
      end
    end
  end

  task automatic set_beat(input logic [M-1:0] m, input logic [IB-1:0] id,
                          input logic [W-1:0] a, input logic l);
    I_VALID  = 1'b1;
    I_MASTER = m;
    I_ID     = id;
    I_ADDR   = a;
    I_LAST   = l;
  endtask

  task automatic send_beat(input logic [M-1:0] m, input logic [IB-1:0] id,
                           input logic [W-1:0] a, input logic l);
    int t;
    t = 0;
    set_beat(m, id, a, l);
    @(negedge CLK);
    while (!I_READY && t < 60) begin
      @(posedge CLK);
      #1;
      t++;
      @(negedge CLK);
    end
    if (!I_READY)
      chk("accept_timeout", 0, 1);
    @(posedge CLK);
    #1;
  endtask

  task automatic drain();
    int t;
    t = 0;
    I_VALID = 1'b0;
    while (sb.size() != 0 && t < 300) begin
      @(posedge CLK);
      t++;
    end
    chk("drain_empty", sb.size(), 0);
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin : main
    int lat, nacc, n, cs0;
    repeat (3) @(posedge CLK);
    #1 RESETN = 1'b1;
    @(negedge CLK);
    chk("rst_rvalid", R_VALID, 0);
    chk("rst_iready", I_READY, 1);
    chk("rst_memcs", MEM_CS, 0);
    chk("rst_rdata", R_DATA, 0);
    @(posedge CLK);
    #1;

    // single beat and minimum latency
    cs0 = cs_cnt;
    send_beat(4'b0010, 4'd3, 22'h000040, 1'b1);
    I_VALID = 1'b0;
    lat = 0;
    do begin
      lat++;
      @(negedge CLK);
    end while (!R_VALID && lat < 20);
    chk("latency", lat, L + 1);
    chk("single_cs", cs_cnt - cs0, 1);
    @(posedge CLK);
    #1;
    drain();

    // back-to-back burst
    for (int k = 0; k < 4; k++)
      send_beat(4'b0001, 4'd5, W'(k * 16), k == 3);
    drain();

    // backpressure: only depth beats fit
    R_READY = 1'b0;
    n = 0;
    nacc = 0;
    set_beat(4'b0001, 4'd0, 22'h0, 1'b0);
    for (int c = 0; c < 12; c++) begin
      @(negedge CLK);
      if (I_VALID && I_READY) begin
        nacc++;
        n++;
      end
      @(posedge CLK);
      #1;
      if (n < 6)
        set_beat(M'(1) << (n % M), IB'(n), W'(n * 16), n == 5);
      else
        I_VALID = 1'b0;
    end
    chk("bp_accepts", nacc, 4);
    @(negedge CLK);
    chk("bp_iready", I_READY, 0);
    chk("bp_rvalid", R_VALID, 1);
    @(posedge CLK);
    #1;
    R_READY = 1'b1;
    for (int k = n; k < 6; k++)
      send_beat(M'(1) << (k % M), IB'(k), W'(k * 16), k == 5);
    drain();

    // out-of-range beat between two good ones
    cs0 = cs_cnt;
    send_beat(4'b0100, 4'd1, 22'h000FF0, 1'b0);
    send_beat(4'b0100, 4'd1, 22'h001000, 1'b0);
    send_beat(4'b0100, 4'd1, 22'h000020, 1'b1);
    drain();
    chk("oor_cs", cs_cnt - cs0, 2);

    // reset after the second of four beats
    send_beat(4'b1000, 4'd7, 22'h000100, 1'b0);
    send_beat(4'b1000, 4'd7, 22'h000110, 1'b0);
    I_VALID = 1'b0;
    RESETN = 1'b0;
    @(posedge CLK);
    #1 RESETN = 1'b1;
    @(negedge CLK);
    chk("mrst_rvalid", R_VALID, 0);
    chk("mrst_iready", I_READY, 1);
    @(posedge CLK);
    #1;
    repeat (6) @(posedge CLK);
    #1;
    send_beat(4'b1000, 4'd7, 22'h000120, 1'b0);
    send_beat(4'b1000, 4'd7, 22'h000130, 1'b1);
    drain();

    // random traffic with random backpressure
    fork
      begin
        for (int b = 0; b < 1000; b++) begin
          if ($urandom_range(0, 3) == 0) begin
            I_VALID = 1'b0;
            @(posedge CLK);
            #1;
          end
          send_beat(M'(1) << $urandom_range(0, M - 1),
                    IB'($urandom_range(0, (1 << IB) - 1)),
                    W'($urandom_range(0, 383) << 4),
                    (b % 4) == 3);
        end
        I_VALID = 1'b0;
        rdone = 1'b1;
      end
      begin
        while (!rdone) begin
          @(posedge CLK);
          #1;
          R_READY = 1'($urandom_range(0, 1));
        end
      end
    join
    R_READY = 1'b1;
    drain();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_rd_beat_resp.md
Name: axi_rd_beat_resp

Overview:
- Consumes the per-beat read requests produced by the AR address latch: master, ID, beat address, last flag, valid/ready.
- Issues one synchronous SRAM read per beat and tracks the reads in flight through a fixed-latency tag pipeline.
- Buffers returned data in a credit-protected response FIFO and drives the AXI R channel back toward the fabric with full backpressure support.
- Sits between the read address latch and the peripheral SRAM macro.

Parameters:
- masters, 4, number of fabric masters; width of the one-hot return-route vector.
- width, 22, peripheral byte-address bits.
- p_size, 4, data width is 2^p_size bytes; data_bits = 8<<p_size (128 by default).
- rd_latency, 2, cycles from MEM_CS to MEM_RDATA valid; legal range 1..4.
- depth, 4, response FIFO entries; must be a power of 2 and >= rd_latency.
- mem_bytes, 4194304, size of the backing store; beats addressed at or above it are answered with DECERR.

Ports:
- CLK  in  1  clock
- RESETN  in  1  synchronous, active-low reset
- I_MASTER  in  masters  return route for the beat
- I_ID  in  `id_bits  transaction ID
- I_ADDR  in  width  beat byte address
- I_LAST  in  1  final beat of the burst
- I_VALID  in  1  beat request valid
- I_READY  out  1  beat request accepted when I_VALID && I_READY
- MEM_CS  out  1  SRAM read strobe, one per accepted in-range beat
- MEM_ADDR  out  width-p_size  SRAM word address, equal to I_ADDR[width-1:p_size]
- MEM_RDATA  in  8<<p_size  SRAM read data, valid rd_latency cycles after MEM_CS
- R_MASTER  out  masters  return route
- R_ID  out  `id_bits  response ID
- R_DATA  out  8<<p_size  read data
- R_RESP  out  2  2'b00 OKAY, 2'b11 DECERR
- R_LAST  out  1  last beat
- R_VALID  out  1  response valid
- R_READY  in  1  response accepted when R_VALID && R_READY

Behaviour:
- Reset (synchronous, RESETN low at posedge CLK):
  - Tag pipeline is cleared to invalid; FIFO pointers and the occupancy counter go to 0; inflight count goes to 0.
  - R_VALID=0 and MEM_CS=0.
  - R_DATA, R_ID, R_MASTER, R_RESP and R_LAST drive 0 whenever R_VALID=0, including during and after reset.
  - A reset mid-burst discards all in-flight beats and FIFO contents; no response is emitted for them.
- Credit and acceptance:
  - I_READY = (inflight + occupancy) < depth. This is combinational from registered state only, with no path from I_VALID.
  - inflight counts accepted beats not yet written into the FIFO.
- Accept cycle (I_VALID && I_READY):
  - MEM_CS is combinational: MEM_CS = I_VALID && I_READY && in_range, where in_range = (I_ADDR < mem_bytes).
  - MEM_ADDR = I_ADDR[width-1:p_size], driven combinationally in the same cycle.
  - Tag {valid=1, MASTER, ID, LAST, resp} enters stage 0 of an rd_latency-deep shift register. resp = in_range ? 00 : 11.
  - Out-of-range beats issue no MEM_CS but still occupy a pipeline slot, so response order is preserved.
- Return:
  - When the tag exits the final stage (rd_latency cycles after accept), the block writes {tag, data} into the FIFO.
  - data = MEM_RDATA for OKAY beats and all-zeros for DECERR beats.
  - The same cycle, inflight decrements and occupancy increments.
  - The credit rule guarantees the FIFO is never full at write time. A write into a full FIFO is an assertion failure.
- R channel:
  - R_VALID = occupancy != 0. R_* fields come from the FIFO head, with no combinational path from MEM_RDATA.
  - Pop on R_VALID && R_READY.
  - R_* fields are held stable while R_VALID && !R_READY.
- Simultaneous events:
  - Accept, FIFO write and pop may all occur in one cycle.
  - inflight nets to +1/-1/0 and occupancy nets accordingly.
  - Pointers wrap modulo depth.
- Latency:
  - Zero-wait minimum: accept at cycle N gives R_VALID at cycle N+rd_latency+1.
  - Sustained throughput is 1 beat/cycle when R_READY is held high and depth >= rd_latency+1.
- Ordering: responses are strictly in acceptance order. I_LAST is passed through unmodified as R_LAST.
- Counter widths: inflight and occupancy are clog2(depth)+1 bits; they never exceed depth.

Test Plan:
- Single beat: I_ADDR=0x000040, ID=3, MASTER=4'b0010, LAST=1, R_READY=1.
  - MEM_CS pulses one cycle with MEM_ADDR=0x4.
  - R_VALID rises 3 cycles after accept with R_DATA=MEM_RDATA model value, R_RESP=00, R_ID=3, R_MASTER=0010, R_LAST=1.
- 4-beat burst, addresses 0x0,0x10,0x20,0x30, I_VALID held, R_READY=1.
  - Four back-to-back accepts; four consecutive R beats in order.
  - R_LAST only on the 4th beat.
- Backpressure: R_READY=0 while a 6-beat burst is offered.
  - I_READY drops after 4 accepts and R_VALID stays high with stable fields.
  - After R_READY is raised, all 6 beats are delivered in order and no FIFO overflow assertion fires.
- Out of range: mem_bytes=0x1000, I_ADDR=0x1000.
  - No MEM_CS.
  - Response R_RESP=11, R_DATA=0, correctly ordered between two OKAY beats.
- Reset mid-burst: assert RESETN=0 for 1 cycle after the 2nd of 4 accepts.
  - Next cycle R_VALID=0, I_READY=1, and no stale responses appear afterward.
- Random I_VALID/R_READY toggling over 1000 beats vs. scoreboard.
  - Exact order and data match.
  - inflight+occupancy never exceeds depth.
